// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
//  Module   : fetch
//  Purpose  : Instruction-fetch stage. Owns the PC, drives a synchronous
//             instruction memory with 1-cycle read latency, absorbs decode
//             stalls with a one-word hold buffer and applies redirects from
//             execute. Presents each instruction/PC pair to decode on
//             fe_to_de; fe_to_de.pc_r=1 marks the slot as a bubble.
//  Ports    : clk         in   rising-edge clock
//             reset_n     in   asynchronous active-low reset
//             en          in   1 = pipeline advances this cycle
//             pc_r        in   redirect request from execute
//             pc_new      in   redirect target (low two bits ignored)
//             imem_addr   out  fetch address (data returns next cycle)
//             imem_rdata  in   word for the address presented last cycle
//             fe_to_de    out  {instruction_value, pc_value, pc_r}
//  Revision : 1.0  initial release
// ============================================================================

package fetch_pkg;
    typedef struct packed {
        logic [31:0] instruction_value;
        logic [31:0] pc_value;
        logic        pc_r;
    } fe_to_de_s;
endpackage

module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        pc_r,
    input  logic [31:0] pc_new,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output fe_to_de_s   fe_to_de
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state;
    state_e      state_nx;
    logic [31:0] pc_q;
    logic [31:0] pc_nx;
    logic [31:0] pc_d_q;
    logic [31:0] pc_d_nx;
    logic [31:0] hold_q;
    logic [31:0] hold_nx;

    // The memory always reads pc_q, so imem_addr is simply the next address.
    assign imem_addr = pc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_FILL;
            pc_q   <= RESET_PC;
            pc_d_q <= RESET_PC;
            hold_q <= 32'h0000_0000;
        end else begin
            state  <= state_nx;
            pc_q   <= pc_nx;
            pc_d_q <= pc_d_nx;
            hold_q <= hold_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        pc_d_nx  = pc_d_q;
        hold_nx  = hold_q;

        fe_to_de.instruction_value = NOP_INSTR;
        fe_to_de.pc_value          = pc_d_q;
        fe_to_de.pc_r              = 1'b1;

        case (state)
            S_RUN: begin
                fe_to_de.instruction_value = imem_rdata;
                fe_to_de.pc_r              = 1'b0;
            end
            S_HOLD: begin
                fe_to_de.instruction_value = hold_q;
                fe_to_de.pc_r              = 1'b0;
            end
            default: begin
            end
        endcase

        if (pc_r) begin
            // Redirect wins over en; the word-aligned target is fetched next
            // and the stale hold contents are never shown again.
            state_nx = S_FILL;
            pc_nx    = pc_new & 32'hFFFF_FFFC;
        end else if (en) begin
            // From every state the word fetched from pc_q arrives on
            // imem_rdata next cycle; during HOLD the memory has been
            // re-reading pc_q, so no refetch is needed.
            state_nx = S_RUN;
            pc_d_nx  = pc_q;
            pc_nx    = pc_q + 32'd4;
        end else if (state == S_RUN) begin
            // imem_rdata will move on next cycle; capture the shown word.
            state_nx = S_HOLD;
            hold_nx  = imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch
//  Purpose  : Scoreboard bench for fetch. A main DUT (RESET_PC=0) takes
//             directed then random en/redirect stimulus; a second DUT with
//             RESET_PC=FFFF_FFFC runs freely to cover address wrap. Both are
//             compared against a slot-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] RST_A   = 32'h0000_0000;
    localparam logic [31:0] RST_W   = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        pc_r;
    logic [31:0] pc_new;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    fe_to_de_s   fe_to_de;
    logic [31:0] imem_addr_w;
    logic [31:0] imem_rdata_w = 32'h0;
    fe_to_de_s   fe_to_de_w;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fetch #(.RESET_PC(RST_A), .NOP_INSTR(NOP)) u_dut (
        .clk(clk), .reset_n(reset_n), .en(en), .pc_r(pc_r), .pc_new(pc_new),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .fe_to_de(fe_to_de)
    );

    fetch #(.RESET_PC(RST_W), .NOP_INSTR(NOP)) u_wrap (
        .clk(clk), .reset_n(reset_n), .en(1'b1), .pc_r(1'b0), .pc_new(32'h0),
        .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w), .fe_to_de(fe_to_de_w)
    );

    // Memory contents: word k holds 1000_0000 + k.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    always_ff @(posedge clk) begin
        imem_rdata   <= mem_word(imem_addr);
        imem_rdata_w <= mem_word(imem_addr_w);
    end

    // Reference model: what decode sees, and which address is fetched next.
    // A stall simply freezes the visible slot.
    typedef struct {
        bit          bubble;
        logic [31:0] shown_pc;
        logic [31:0] next_addr;
    } model_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        bub;
        logic [31:0] addr;
    } exp_t;

    model_t m_main;
    model_t m_wrap;
    exp_t   q_main[$];
    exp_t   q_wrap[$];

    function automatic model_t model_reset(input logic [31:0] rp);
        model_t m;
        m.bubble    = 1'b1;
        m.shown_pc  = rp;
        m.next_addr = rp;
        return m;
    endfunction

    function automatic model_t model_clock(input model_t mi, input logic e,
                                           input logic r, input logic [31:0] t);
        model_t m = mi;
        if (r) begin
            m.bubble    = 1'b1;
            m.next_addr = t - (t % 32'd4);
        end else if (e) begin
            m.bubble    = 1'b0;
            m.shown_pc  = m.next_addr;
            m.next_addr = m.next_addr + 32'd4;
        end
        return m;
    endfunction

    function automatic exp_t expect_of(input model_t m);
        exp_t x;
        x.instr = m.bubble ? NOP : mem_word(m.shown_pc);
        x.pc    = m.shown_pc;
        x.bub   = m.bubble;
        x.addr  = m.next_addr;
        return x;
    endfunction

    task automatic push_reset_expect();
        m_main = model_reset(RST_A);
        m_wrap = model_reset(RST_W);
        q_main.push_back(expect_of(m_main));
        q_wrap.push_back(expect_of(m_wrap));
    endtask

    task automatic step(input logic e, input logic r, input logic [31:0] t);
        en     = e;
        pc_r   = r;
        pc_new = t;
        @(posedge clk);
        m_main = model_clock(m_main, e, r, t);
        m_wrap = model_clock(m_wrap, 1'b1, 1'b0, 32'h0);
        q_main.push_back(expect_of(m_main));
        q_wrap.push_back(expect_of(m_wrap));
        #1;
    endtask

    // Monitor: compares whatever the DUTs present at each falling edge.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q_main.size() != 0) begin
                x = q_main.pop_front();
                chk("main.instruction_value", fe_to_de.instruction_value, x.instr);
                chk("main.pc_value", fe_to_de.pc_value, x.pc);
                chk("main.pc_r", {31'b0, fe_to_de.pc_r}, {31'b0, x.bub});
                chk("main.imem_addr", imem_addr, x.addr);
            end
            if (q_wrap.size() != 0) begin
                x = q_wrap.pop_front();
                chk("wrap.instruction_value", fe_to_de_w.instruction_value, x.instr);
                chk("wrap.pc_value", fe_to_de_w.pc_value, x.pc);
                chk("wrap.pc_r", {31'b0, fe_to_de_w.pc_r}, {31'b0, x.bub});
                chk("wrap.imem_addr", imem_addr_w, x.addr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        pc_r    = 1'b0;
        pc_new  = 32'h0;
        push_reset_expect();
        #12 reset_n = 1'b1;

        // Boot sequence with en held high.
        repeat (3) step(1'b1, 1'b0, 32'h0);
        // Three-cycle stall, then resume.
        repeat (3) step(1'b0, 1'b0, 32'h0);
        repeat (2) step(1'b1, 1'b0, 32'h0);
        // Redirect from RUN.
        step(1'b1, 1'b1, 32'h0000_0100);
        repeat (2) step(1'b1, 1'b0, 32'h0);
        // Redirect while stalled in HOLD with a misaligned target.
        repeat (2) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0203);
        step(1'b0, 1'b0, 32'h0);
        repeat (2) step(1'b1, 1'b0, 32'h0);
        // Redirect while in FILL, then stall inside FILL.
        step(1'b1, 1'b1, 32'h0000_0040);
        step(1'b1, 1'b1, 32'h0000_0080);
        step(1'b0, 1'b0, 32'h0);
        repeat (2) step(1'b1, 1'b0, 32'h0);

        // Asynchronous reset asserted mid-HOLD, between clock edges.
        repeat (2) step(1'b0, 1'b0, 32'h0);
        #1;
        reset_n = 1'b0;
        q_main.delete();
        q_wrap.delete();
        push_reset_expect();
        @(posedge clk);
        push_reset_expect();
        #2 reset_n = 1'b1;
        en = 1'b1;
        repeat (3) step(1'b1, 1'b0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_0FFF) : $urandom);
        end

        step(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
